calc_core: RTL and testbench
============================

Name: calc_core

Overview:
- Arithmetic engine directly downstream of NumberGenerator.
- Consumes the two 32-bit unsigned operands numA/numB plus a switch-selected operation.
- Produces a registered result for the display stage.
- Add/sub complete in one cycle; multiply (shift-add) and divide (restoring) iterate one bit per cycle, so the board clock needs no wide combinational multiplier/divider.

Parameters:
- WIDTH, 32, operand/result width in bits.
- CNT_W, 5, iteration counter width (2^CNT_W must be at least WIDTH).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- numA  input  WIDTH  operand A (unsigned), from NumberGenerator.
- numB  input  WIDTH  operand B (unsigned), from NumberGenerator.
- op  input  2  operation: 00 add, 01 sub, 10 mul, 11 div.
- start  input  1  single-cycle request pulse (already debounced/edge-detected upstream).
- busy  output  1  high while an iterative operation is in progress.
- done  output  1  one-cycle pulse: result/flags valid.
- result  output  WIDTH  sum, difference, product low word, or quotient.
- remainder  output  WIDTH  division remainder; 0 for all other ops.
- ovf  output  1  add carry-out / sub borrow / product high word nonzero.
- dz  output  1  divide by zero.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; busy=0, done=0, result=0, remainder=0, ovf=0, dz=0; counter and internal accumulators cleared. Takes effect immediately, including mid-operation. An aborted operation never produces done.
- States:
  - IDLE: waiting for a request.
  - MUL: shift-add multiply in progress.
  - DIV: restoring divide in progress.
- Accept rule: start is sampled only in IDLE. numA, numB and op are latched on the accepting edge (edge T); later input changes have no effect on that operation. start while busy=1 or in the done cycle is ignored; no queueing.
- Add/sub: computed on edge T, done=1 in the cycle after T, busy stays 0.
  - Add: result = (A+B) mod 2^WIDTH; ovf = carry-out.
  - Sub: result = (A-B) mod 2^WIDTH; ovf = 1 iff A<B.
- Mul: IDLE -> MUL at T, busy=1. One multiplier bit per edge for exactly WIDTH edges, using a 2*WIDTH-bit accumulator. On the final iteration edge (T+WIDTH): MUL -> IDLE, busy=0, done=1.
  - result = product[WIDTH-1:0].
  - ovf = |product[2*WIDTH-1:WIDTH].
- Div: IDLE -> DIV at T, busy=1. WIDTH restoring iterations; done at edge T+WIDTH as for mul.
  - result = floor(A/B); remainder = A mod B; ovf=0.
- Divide by zero (op=11, B=0): no DIV state; handled like add/sub timing with done in the cycle after T.
  - dz=1, result = all ones, remainder = A, ovf=0.
- Latency: done rises 1 edge after accept for add/sub/div-by-zero, WIDTH+1 edges after accept for mul/div (WIDTH=32: busy high 32 cycles, done in cycle 33).
- done is high for exactly one cycle. result, remainder, ovf and dz hold their values until the next accepted start. On accept they are not cleared; they update only at that operation's done.
- A start in the cycle immediately after done is accepted (IDLE).

Test Plan:
- Reset then op=00, A=0xFFFFFFFF, B=2, start pulse -> next cycle done=1, result=0x00000001, ovf=1, busy never high.
- op=01, A=5, B=7 -> done after 1 cycle, result=0xFFFFFFFE, ovf=1; then A=7, B=5 -> result=2, ovf=0.
- op=10, A=0x00010000, B=0x00010000; change A to 3 during busy -> busy high 32 cycles, done in cycle 33, result=0, ovf=1; repeat with A=1234, B=5678 -> result=7006652, ovf=0.
- op=11, A=100, B=7 -> done at cycle 33, result=14, remainder=2; then B=0 -> done after 1 cycle, dz=1, result=0xFFFFFFFF, remainder=100.
- Start pulses at cycles 5 and 20 of a mul -> second ignored, exactly one done; start in the cycle right after done -> accepted.
- rst_n low at cycle 10 of a div -> all outputs 0 immediately, no done; after release a new add completes normally.

Source files
------------

// File: rtl/calc_core_if.sv
// Operand/request and result bundle between NumberGenerator, calc_core and the display stage.
interface calc_core_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] numA;
  logic [WIDTH-1:0] numB;
  logic [1:0]       op;
  logic             start;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] remainder;
  logic             ovf;
  logic             dz;

  modport master (
    output numA, numB, op, start,
    input  busy, done, result, remainder, ovf, dz
  );

  modport slave (
    input  numA, numB, op, start,
    output busy, done, result, remainder, ovf, dz
  );
endinterface

// File: rtl/calc_core.sv
// Add/sub in one cycle; shift-add multiply and restoring divide at one bit per cycle.
module calc_core #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic      clk,
  input  logic      rst_n,
  calc_core_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t             r_state,     w_state_next;
  logic [CNT_W-1:0]   r_cnt,       w_cnt_next;
  logic [2*WIDTH-1:0] r_acc,       w_acc_next;
  logic [2*WIDTH-1:0] r_mcand,     w_mcand_next;
  logic [WIDTH-1:0]   r_mplier,    w_mplier_next;
  logic [WIDTH-1:0]   r_rem,       w_rem_next;
  logic [WIDTH-1:0]   r_quot,      w_quot_next;
  logic [WIDTH-1:0]   r_divisor,   w_divisor_next;
  logic [WIDTH-1:0]   r_result,    w_result_next;
  logic [WIDTH-1:0]   r_remainder, w_remainder_next;
  logic               r_ovf,       w_ovf_next;
  logic               r_dz,        w_dz_next;
  logic               r_done,      w_done_next;

  logic               w_accept;
  logic               w_last;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_mul_acc;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_trial;
  logic [WIDTH-1:0]   w_div_quot;
  logic [WIDTH-1:0]   w_div_rem;

  // Requests landing in the done cycle are dropped, not queued.
  assign w_accept = (r_state == S_IDLE) && bus.start && !r_done;
  assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_sum    = {1'b0, bus.numA} + {1'b0, bus.numB};
  assign w_diff   = {1'b0, bus.numA} - {1'b0, bus.numB};
  assign w_mul_acc = r_acc + (r_mplier[0] ? r_mcand : '0);

  // Restoring step: bring in the next dividend bit, keep the difference only if it did not borrow.
  assign w_shift    = {r_rem, r_quot[WIDTH-1]};
  assign w_trial    = w_shift - {1'b0, r_divisor};
  assign w_div_quot = {r_quot[WIDTH-2:0], ~w_trial[WIDTH]};
  assign w_div_rem  = w_trial[WIDTH] ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_rem       <= '0;
      r_quot      <= '0;
      r_divisor   <= '0;
      r_result    <= '0;
      r_remainder <= '0;
      r_ovf       <= 1'b0;
      r_dz        <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_acc       <= w_acc_next;
      r_mcand     <= w_mcand_next;
      r_mplier    <= w_mplier_next;
      r_rem       <= w_rem_next;
      r_quot      <= w_quot_next;
      r_divisor   <= w_divisor_next;
      r_result    <= w_result_next;
      r_remainder <= w_remainder_next;
      r_ovf       <= w_ovf_next;
      r_dz        <= w_dz_next;
      r_done      <= w_done_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_cnt_next       = r_cnt;
    w_acc_next       = r_acc;
    w_mcand_next     = r_mcand;
    w_mplier_next    = r_mplier;
    w_rem_next       = r_rem;
    w_quot_next      = r_quot;
    w_divisor_next   = r_divisor;
    w_result_next    = r_result;
    w_remainder_next = r_remainder;
    w_ovf_next       = r_ovf;
    w_dz_next        = r_dz;
    w_done_next      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (bus.op)
            2'b00: begin
              w_result_next    = w_sum[WIDTH-1:0];
              w_remainder_next = '0;
              w_ovf_next       = w_sum[WIDTH];
              w_dz_next        = 1'b0;
              w_done_next      = 1'b1;
            end
            2'b01: begin
              w_result_next    = w_diff[WIDTH-1:0];
              w_remainder_next = '0;
              w_ovf_next       = w_diff[WIDTH];
              w_dz_next        = 1'b0;
              w_done_next      = 1'b1;
            end
            2'b10: begin
              w_acc_next    = '0;
              w_mcand_next  = {{WIDTH{1'b0}}, bus.numA};
              w_mplier_next = bus.numB;
              w_cnt_next    = '0;
              w_state_next  = S_MUL;
            end
            default: begin
              if (bus.numB == '0) begin
                w_result_next    = '1;
                w_remainder_next = bus.numA;
                w_ovf_next       = 1'b0;
                w_dz_next        = 1'b1;
                w_done_next      = 1'b1;
              end else begin
                w_rem_next     = '0;
                w_quot_next    = bus.numA;
                w_divisor_next = bus.numB;
                w_cnt_next     = '0;
                w_state_next   = S_DIV;
              end
            end
          endcase
        end
      end
      S_MUL: begin
        w_acc_next    = w_mul_acc;
        w_mcand_next  = {r_mcand[2*WIDTH-2:0], 1'b0};
        w_mplier_next = {1'b0, r_mplier[WIDTH-1:1]};
        w_cnt_next    = r_cnt + CNT_W'(1);
        if (w_last) begin
          w_result_next    = w_mul_acc[WIDTH-1:0];
          w_remainder_next = '0;
          w_ovf_next       = |w_mul_acc[2*WIDTH-1:WIDTH];
          w_dz_next        = 1'b0;
          w_done_next      = 1'b1;
          w_state_next     = S_IDLE;
        end
      end
      S_DIV: begin
        w_rem_next  = w_div_rem;
        w_quot_next = w_div_quot;
        w_cnt_next  = r_cnt + CNT_W'(1);
        if (w_last) begin
          w_result_next    = w_div_quot;
          w_remainder_next = w_div_rem;
          w_ovf_next       = 1'b0;
          w_dz_next        = 1'b0;
          w_done_next      = 1'b1;
          w_state_next     = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = r_done;
  assign bus.result    = r_result;
  assign bus.remainder = r_remainder;
  assign bus.ovf       = r_ovf;
  assign bus.dz        = r_dz;
endmodule

// File: tb/tb_calc_core.sv
// Directed vector table for calc_core plus hand-written start-ignore and mid-divide reset sequences.
module tb_calc_core;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;

  calc_core_if #(.WIDTH(32)) bus ();

  calc_core #(.WIDTH(32), .CNT_W(5)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [31:0] rem;
    logic        ovf;
    logic        dz;
    int          lat;
    int          busy;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Pulse start, then scramble the inputs so the operation must rely on its latched copy.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int busy_cnt);
    @(negedge clk);
    bus.op = op; bus.numA = a; bus.numB = b; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.numA = 32'h3; bus.numB = 32'h9; bus.op = ~op;
    lat = 1; busy_cnt = 0;
    while (!bus.done && lat < 100) begin
      if (bus.busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat, bcnt, dones;
    bus.numA = '0; bus.numB = '0; bus.op = 2'b00; bus.start = 1'b0;

    vecs[0]  = '{2'b00, 32'hFFFFFFFF, 32'h2,        32'h1,        32'h0, 1'b1, 1'b0, 1,  0};
    vecs[1]  = '{2'b01, 32'h5,        32'h7,        32'hFFFFFFFE, 32'h0, 1'b1, 1'b0, 1,  0};
    vecs[2]  = '{2'b01, 32'h7,        32'h5,        32'h2,        32'h0, 1'b0, 1'b0, 1,  0};
    vecs[3]  = '{2'b10, 32'h00010000, 32'h00010000, 32'h0,        32'h0, 1'b1, 1'b0, 33, 32};
    vecs[4]  = '{2'b10, 32'd1234,     32'd5678,     32'd7006652,  32'h0, 1'b0, 1'b0, 33, 32};
    vecs[5]  = '{2'b11, 32'd100,      32'd7,        32'd14,       32'd2, 1'b0, 1'b0, 33, 32};
    vecs[6]  = '{2'b11, 32'd100,      32'd0,        32'hFFFFFFFF, 32'd100, 1'b0, 1'b1, 1, 0};
    vecs[7]  = '{2'b00, 32'h12345678, 32'h11111111, 32'h23456789, 32'h0, 1'b0, 1'b0, 1,  0};
    vecs[8]  = '{2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1,        32'h0, 1'b1, 1'b0, 33, 32};
    vecs[9]  = '{2'b11, 32'hFFFFFFFF, 32'h1,        32'hFFFFFFFF, 32'h0, 1'b0, 1'b0, 33, 32};
    vecs[10] = '{2'b11, 32'd5,        32'd9,        32'd0,        32'd5, 1'b0, 1'b0, 33, 32};
    vecs[11] = '{2'b10, 32'd0,        32'd77,       32'd0,        32'h0, 1'b0, 1'b0, 33, 32};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", {63'd0, bus.busy}, 64'd0);
    chk("rst_done", {63'd0, bus.done}, 64'd0);
    chk("rst_result", {32'd0, bus.result}, 64'd0);
    chk("rst_rem", {32'd0, bus.remainder}, 64'd0);
    chk("rst_flags", {62'd0, bus.ovf, bus.dz}, 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bcnt);
      $display("txn %0d op=%0d a=%h b=%h -> result=%h rem=%h ovf=%0b dz=%0b lat=%0d busy=%0d",
               i, vecs[i].op, vecs[i].a, vecs[i].b, bus.result, bus.remainder,
               bus.ovf, bus.dz, lat, bcnt);
      chk($sformatf("v%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
      chk($sformatf("v%0d_busy", i), 64'(bcnt), 64'(vecs[i].busy));
      chk($sformatf("v%0d_result", i), {32'd0, bus.result}, {32'd0, vecs[i].res});
      chk($sformatf("v%0d_rem", i), {32'd0, bus.remainder}, {32'd0, vecs[i].rem});
      chk($sformatf("v%0d_ovf", i), {63'd0, bus.ovf}, {63'd0, vecs[i].ovf});
      chk($sformatf("v%0d_dz", i), {63'd0, bus.dz}, {63'd0, vecs[i].dz});
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", i), {63'd0, bus.done}, 64'd0);
      chk($sformatf("v%0d_hold", i), {32'd0, bus.result}, {32'd0, vecs[i].res});
    end

    // Mul with stray starts at cycles 5 and 20; then a start in the done cycle and one after it
    @(negedge clk);
    bus.op = 2'b10; bus.numA = 32'd3; bus.numB = 32'd4; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    dones = 0; lat = 1;
    while (!bus.done && lat < 100) begin
      if (lat == 5 || lat == 20) begin
        bus.op = 2'b00; bus.numA = 32'd1; bus.numB = 32'd1; bus.start = 1'b1;
      end
      @(negedge clk);
      bus.start = 1'b0;
      lat++;
    end
    $display("txn mul_ignore result=%h lat=%0d", bus.result, lat);
    chk("ign_lat", 64'(lat), 64'd33);
    chk("ign_result", {32'd0, bus.result}, 64'd12);
    bus.op = 2'b00; bus.numA = 32'd1; bus.numB = 32'd1; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("donecyc_start_ignored", {63'd0, bus.done}, 64'd0);
    chk("donecyc_hold", {32'd0, bus.result}, 64'd12);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    chk("no_queued_done", 64'(dones), 64'd0);
    run_op(2'b00, 32'd2, 32'd3, lat, bcnt);
    $display("txn after_done add result=%h lat=%0d", bus.result, lat);
    chk("after_done_lat", 64'(lat), 64'd1);
    chk("after_done_result", {32'd0, bus.result}, 64'd5);

    // Asynchronous reset in the middle of a divide
    @(negedge clk);
    bus.op = 2'b11; bus.numA = 32'd100; bus.numB = 32'd7; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    chk("pre_rst_busy", {63'd0, bus.busy}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", {63'd0, bus.busy}, 64'd0);
    chk("mid_rst_result", {32'd0, bus.result}, 64'd0);
    chk("mid_rst_rem", {32'd0, bus.remainder}, 64'd0);
    chk("mid_rst_flags", {62'd0, bus.ovf, bus.dz}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.done || bus.busy) dones++;
    end
    chk("aborted_no_done", 64'(dones), 64'd0);
    run_op(2'b00, 32'd4, 32'd5, lat, bcnt);
    $display("txn post_rst add result=%h lat=%0d", bus.result, lat);
    chk("post_rst_lat", 64'(lat), 64'd1);
    chk("post_rst_result", {32'd0, bus.result}, 64'd9);
    chk("post_rst_ovf", {63'd0, bus.ovf}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
